// File: rtl/i2c_poll_sched.sv
// i2c_poll_sched: periodic two-device temperature poller driving a byte-read
// I2C engine. A free-running tick starts a round that reads device 0 and then
// device 1. Each good byte is stored, and an unacknowledged read is flagged.
// Optional build macro I2C_POLL_TIMEOUT_EN adds a per-transaction watchdog.
// Without the macro there is no watchdog, and the FSM waits on END_OK forever.
module i2c_poll_sched #(
  parameter logic [7:0]  DEV0_ADDR   = 8'h98,
  parameter logic [7:0]  DEV1_ADDR   = 8'h9A,
  parameter int unsigned TICK_DIV    = 50000,
  parameter int unsigned TIMEOUT_CYC = 4095
) (
  input  logic       PT_CK,
  input  logic       RESET_N,
  input  logic       ENABLE,
  output logic [7:0] SLAVE_ADDRESS,
  output logic       GO,
  input  logic       END_OK,
  input  logic       ACK_OK,
  input  logic [7:0] DATA8,
  output logic [7:0] TEMP0,
  output logic [7:0] TEMP1,
  output logic [1:0] VALID,
  output logic [1:0] NACK_ERR,
  output logic       TIMEOUT_ERR,
  output logic       POLL_DONE
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] ISSUE     = 3'd1;
  localparam logic [2:0] WAIT_BUSY = 3'd2;
  localparam logic [2:0] WAIT_DONE = 3'd3;
  localparam logic [2:0] STORE     = 3'd4;
  localparam logic [2:0] NEXT      = 3'd5;

  localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);

  // An out-of-range configuration never raises a poll tick, so a bad
  // parameter shows up as a dead scheduler instead of odd timing.
  localparam bit PARAMS_OK = (TICK_DIV >= 16) && (TICK_DIV <= 65535) &&
                             (TIMEOUT_CYC >= 64) && (TIMEOUT_CYC <= 65535);

  logic [2:0]  state;
  logic [15:0] tick_cnt;
  logic        poll_tick;
  logic        issue_cnt;
  logic        dev_sel;
  logic        ack_latch;
  logic        stop_req;
  logic        wdog_expire;
  logic        in_wait;

  assign in_wait = (state == WAIT_BUSY) || (state == WAIT_DONE);

  // Poll period counter: runs only while enabled, and sits at 0 otherwise.
  always_ff @(posedge PT_CK or negedge RESET_N) begin
    if (!RESET_N) begin
      tick_cnt <= 16'd0;
    end else if (!ENABLE) begin
      tick_cnt <= 16'd0;
    end else if (tick_cnt == TICK_LAST) begin
      tick_cnt <= 16'd0;
    end else begin
      tick_cnt <= tick_cnt + 16'd1;
    end
  end

  assign poll_tick = PARAMS_OK && ENABLE && (tick_cnt == TICK_LAST);

`ifdef I2C_POLL_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYC - 1);

  logic [15:0] wdog;

  // Watchdog: restarts while a request is issued and ages while the engine is busy.
  always_ff @(posedge PT_CK or negedge RESET_N) begin
    if (!RESET_N) begin
      wdog <= 16'd0;
    end else if (state == ISSUE) begin
      wdog <= 16'd0;
    end else if (in_wait) begin
      wdog <= wdog + 16'd1;
    end
  end

  assign wdog_expire = in_wait && (wdog == TIMEOUT_LAST);

  // Sticky timeout flag; only reset clears it.
  always_ff @(posedge PT_CK or negedge RESET_N) begin
    if (!RESET_N) begin
      TIMEOUT_ERR <= 1'b0;
    end else if (wdog_expire) begin
      TIMEOUT_ERR <= 1'b1;
    end
  end
`else
  assign wdog_expire = 1'b0;
  assign TIMEOUT_ERR = 1'b0;
`endif

  // Round sequencer: issues each read, tracks the ACK, and stores the result.
  always_ff @(posedge PT_CK or negedge RESET_N) begin
    if (!RESET_N) begin
      state         <= IDLE;
      issue_cnt     <= 1'b0;
      dev_sel       <= 1'b0;
      ack_latch     <= 1'b0;
      stop_req      <= 1'b0;
      GO            <= 1'b0;
      SLAVE_ADDRESS <= DEV0_ADDR;
      TEMP0         <= 8'd0;
      TEMP1         <= 8'd0;
      VALID         <= 2'b00;
      NACK_ERR      <= 2'b00;
      POLL_DONE     <= 1'b0;
    end else begin
      POLL_DONE <= 1'b0;
      if ((state != IDLE) && !ENABLE) begin
        stop_req <= 1'b1;
      end
      case (state)
        IDLE: begin
          stop_req <= 1'b0;
          if (poll_tick) begin
            state         <= ISSUE;
            dev_sel       <= 1'b0;
            SLAVE_ADDRESS <= DEV0_ADDR;
            GO            <= 1'b1;
            issue_cnt     <= 1'b0;
            ack_latch     <= 1'b0;
          end
        end
        ISSUE: begin
          if (issue_cnt) begin
            GO    <= 1'b0;
            state <= WAIT_BUSY;
          end else begin
            issue_cnt <= 1'b1;
          end
        end
        WAIT_BUSY: begin
          if (wdog_expire) begin
            NACK_ERR[dev_sel] <= 1'b1;
            state             <= NEXT;
          end else if (!END_OK) begin
            state <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (wdog_expire) begin
            NACK_ERR[dev_sel] <= 1'b1;
            state             <= NEXT;
          end else begin
            if (ACK_OK) begin
              ack_latch <= 1'b1;
            end
            if (END_OK) begin
              state <= STORE;
            end
          end
        end
        STORE: begin
          if (ack_latch) begin
            if (dev_sel) begin
              TEMP1 <= DATA8;
            end else begin
              TEMP0 <= DATA8;
            end
            VALID[dev_sel]    <= 1'b1;
            NACK_ERR[dev_sel] <= 1'b0;
          end else begin
            NACK_ERR[dev_sel] <= 1'b1;
          end
          state <= NEXT;
        end
        NEXT: begin
          if (stop_req || !ENABLE) begin
            state <= IDLE;
          end else if (!dev_sel) begin
            state         <= ISSUE;
            dev_sel       <= 1'b1;
            SLAVE_ADDRESS <= DEV1_ADDR;
            GO            <= 1'b1;
            issue_cnt     <= 1'b0;
            ack_latch     <= 1'b0;
          end else begin
            state     <= IDLE;
            POLL_DONE <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          GO    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_poll_sched.sv
// tb_i2c_poll_sched: randomized bench for i2c_poll_sched. A reactive engine
// model answers each GO request. A per-device result model predicts TEMP,
// VALID, NACK_ERR and TIMEOUT_ERR. Timeout behaviour follows I2C_POLL_TIMEOUT_EN.
module tb_i2c_poll_sched;

  localparam int TICK = 16;
  localparam int TO   = 64;
  localparam logic [7:0] A0 = 8'h98;
  localparam logic [7:0] A1 = 8'h9A;

  logic       PT_CK = 1'b0;
  logic       RESET_N = 1'b0;
  logic       ENABLE = 1'b0;
  logic       END_OK = 1'b1;
  logic       ACK_OK = 1'b0;
  logic [7:0] DATA8 = 8'h00;
  logic [7:0] SLAVE_ADDRESS;
  logic       GO;
  logic [7:0] TEMP0;
  logic [7:0] TEMP1;
  logic [1:0] VALID;
  logic [1:0] NACK_ERR;
  logic       TIMEOUT_ERR;
  logic       POLL_DONE;

  int compared = 0;
  int mismatched = 0;
  int pd_count = 0;

  logic [7:0] m_temp [2];
  logic [1:0] m_valid;
  logic [1:0] m_nack;
  logic       m_to;

  i2c_poll_sched #(
    .DEV0_ADDR(A0), .DEV1_ADDR(A1), .TICK_DIV(TICK), .TIMEOUT_CYC(TO)
  ) dut (
    .PT_CK(PT_CK), .RESET_N(RESET_N), .ENABLE(ENABLE),
    .SLAVE_ADDRESS(SLAVE_ADDRESS), .GO(GO), .END_OK(END_OK), .ACK_OK(ACK_OK),
    .DATA8(DATA8), .TEMP0(TEMP0), .TEMP1(TEMP1), .VALID(VALID),
    .NACK_ERR(NACK_ERR), .TIMEOUT_ERR(TIMEOUT_ERR), .POLL_DONE(POLL_DONE)
  );

  always #5 PT_CK = ~PT_CK;

  // Count every POLL_DONE cycle seen at a rising edge.
  always @(posedge PT_CK) begin
    if (POLL_DONE === 1'b1) pd_count++;
  end

  task automatic step();
    @(negedge PT_CK);
  endtask

  function automatic logic [7:0] addr_of(input int dev);
    return (dev == 0) ? A0 : A1;
  endfunction

  task automatic model_reset();
    m_temp[0] = 8'h00;
    m_temp[1] = 8'h00;
    m_valid = 2'b00;
    m_nack = 2'b00;
    m_to = 1'b0;
  endtask

  task automatic check_results(input string name);
    compared++;
    if ({TEMP0, TEMP1, VALID, NACK_ERR, TIMEOUT_ERR} !==
        {m_temp[0], m_temp[1], m_valid, m_nack, m_to}) begin
      mismatched++;
      $display("[TB] FAIL %s: got T0=%h T1=%h V=%b N=%b TO=%b, expected T0=%h T1=%h V=%b N=%b TO=%b",
               name, TEMP0, TEMP1, VALID, NACK_ERR, TIMEOUT_ERR,
               m_temp[0], m_temp[1], m_valid, m_nack, m_to);
    end
  endtask

  task automatic wait_go(input string name, input int limit, output int n);
    n = 0;
    while (GO !== 1'b1 && n < limit) begin
      step();
      n++;
    end
    compared++;
    if (GO !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL %s: GO=%b after %0d cycles, required 1", name, GO, n);
    end
  endtask

  // Serve one transaction from GO onwards and check the stored outcome.
  task automatic run_txn(input int dev, input bit ack, input logic [7:0] data,
                         input int pre, input int busy, input bit drop_en);
    int n;
    int g;
    wait_go($sformatf("go_wait_dev%0d", dev), 200, n);
    compared++;
    if (SLAVE_ADDRESS !== addr_of(dev)) begin
      mismatched++;
      $display("[TB] FAIL addr_dev%0d: got %h, expected %h", dev, SLAVE_ADDRESS, addr_of(dev));
    end
    g = 0;
    while (GO === 1'b1 && g < 10) begin
      g++;
      step();
    end
    compared++;
    if (g != 2) begin
      mismatched++;
      $display("[TB] FAIL go_width_dev%0d: got %0d cycles, expected 2", dev, g);
    end
    repeat (pre) step();
    END_OK = 1'b0;
    ACK_OK = ack;
    for (int i = 0; i < busy; i++) begin
      step();
      if (drop_en && i == 1) ENABLE = 1'b0;
    end
    END_OK = 1'b1;
    ACK_OK = 1'b0;
    DATA8 = data;
    step();
    step();
    DATA8 = ~data;
    if (ack) begin
      m_temp[dev] = data;
      m_valid[dev] = 1'b1;
      m_nack[dev] = 1'b0;
    end else begin
      m_nack[dev] = 1'b1;
    end
    check_results($sformatf("store_dev%0d", dev));
    compared++;
    if (SLAVE_ADDRESS !== addr_of(dev)) begin
      mismatched++;
      $display("[TB] FAIL addr_hold_dev%0d: got %h, expected %h", dev, SLAVE_ADDRESS, addr_of(dev));
    end
  endtask

  // After device 1 completes, expect exactly one POLL_DONE cycle.
  task automatic finish_round(input string name);
    compared++;
    if (POLL_DONE !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL %s_pd_early: got %b, expected 0", name, POLL_DONE);
    end
    step();
    compared++;
    if (POLL_DONE !== 1'b1 || SLAVE_ADDRESS !== A1) begin
      mismatched++;
      $display("[TB] FAIL %s_pd_pulse: got pd=%b addr=%h, expected pd=1 addr=%h", name, POLL_DONE, SLAVE_ADDRESS, A1);
    end
    step();
    compared++;
    if (POLL_DONE !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL %s_pd_width: got %b, expected 0", name, POLL_DONE);
    end
  endtask

  task automatic check_latency(input string name, input logic [7:0] addr);
    int n;
    wait_go(name, 200, n);
    compared++;
    if (n != TICK || SLAVE_ADDRESS !== addr) begin
      mismatched++;
      $display("[TB] FAIL %s_latency: got %0d cycles addr=%h, expected %0d cycles addr=%h", name, n, SLAVE_ADDRESS, TICK, addr);
    end
  endtask

  task automatic random_round(input string name);
    bit a0, a1;
    a0 = ($urandom_range(0, 3) != 0);
    a1 = ($urandom_range(0, 3) != 0);
    run_txn(0, a0, 8'($urandom_range(0, 255)), $urandom_range(0, 3), $urandom_range(2, 6), 1'b0);
    compared++;
    if (POLL_DONE !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL %s_pd_mid: got %b, expected 0", name, POLL_DONE);
    end
    run_txn(1, a1, 8'($urandom_range(0, 255)), $urandom_range(0, 3), $urandom_range(2, 6), 1'b0);
    finish_round(name);
  endtask

  task automatic test_reset();
    model_reset();
    RESET_N = 1'b0;
    ENABLE = 1'b0;
    repeat (3) step();
    compared++;
    if ({SLAVE_ADDRESS, GO, POLL_DONE} !== {A0, 1'b0, 1'b0}) begin
      mismatched++;
      $display("[TB] FAIL reset_ctrl: got addr=%h go=%b pd=%b, expected %h 0 0", SLAVE_ADDRESS, GO, POLL_DONE, A0);
    end
    check_results("reset_data");
    RESET_N = 1'b1;
    for (int i = 0; i < 3 * TICK; i++) begin
      step();
      if (GO !== 1'b0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL idle_disabled: got GO=%b, expected 0", GO);
        break;
      end
    end
  endtask

  task automatic test_basic_round();
    ENABLE = 1'b1;
    check_latency("basic", A0);
    run_txn(0, 1'b1, 8'h2A, 1, 3, 1'b0);
    run_txn(1, 1'b1, 8'h31, 2, 4, 1'b0);
    finish_round("basic");
  endtask

  task automatic test_random_rounds();
    for (int r = 0; r < 5; r++) random_round($sformatf("rand%0d", r));
  endtask

  task automatic test_nack();
    run_txn(0, 1'b1, 8'($urandom_range(0, 255)), 0, 3, 1'b0);
    run_txn(1, 1'b1, 8'h31, 1, 3, 1'b0);
    finish_round("nack_prep");
    run_txn(0, 1'b1, 8'($urandom_range(0, 255)), 2, 2, 1'b0);
    run_txn(1, 1'b0, 8'h77, 1, 5, 1'b0);
    finish_round("nack");
    compared++;
    if (NACK_ERR !== 2'b10 || TEMP1 !== 8'h31 || VALID[1] !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL nack_dev1: got N=%b T1=%h V1=%b, expected 10 31 1", NACK_ERR, TEMP1, VALID[1]);
    end
  endtask

  task automatic test_enable_drop();
    int pd_before;
    int go_seen;
    pd_before = pd_count;
    run_txn(0, 1'b1, 8'($urandom_range(0, 255)), 1, 4, 1'b1);
    go_seen = 0;
    for (int i = 0; i < 3 * TICK; i++) begin
      step();
      if (GO === 1'b1) go_seen++;
    end
    compared++;
    if (go_seen != 0 || pd_count != pd_before) begin
      mismatched++;
      $display("[TB] FAIL enable_drop: got go=%0d pd=%0d, expected 0 0", go_seen, pd_count - pd_before);
    end
    check_results("enable_drop_hold");
    ENABLE = 1'b1;
    check_latency("reenable", A0);
    random_round("reenable");
  endtask

  task automatic test_reset_mid();
    int n;
    wait_go("rst_go", 200, n);
    repeat (2) step();
    END_OK = 1'b0;
    ACK_OK = 1'b1;
    repeat (2) step();
    #2 RESET_N = 1'b0;
    #1;
    model_reset();
    compared++;
    if ({SLAVE_ADDRESS, GO, POLL_DONE} !== {A0, 1'b0, 1'b0}) begin
      mismatched++;
      $display("[TB] FAIL reset_mid_ctrl: got addr=%h go=%b pd=%b, expected %h 0 0", SLAVE_ADDRESS, GO, POLL_DONE, A0);
    end
    check_results("reset_mid_data");
    END_OK = 1'b1;
    ACK_OK = 1'b0;
    step();
    step();
    RESET_N = 1'b1;
    check_latency("after_reset", A0);
    random_round("after_reset");
  endtask

  task automatic test_timeout();
    int n;
    wait_go("to_go", 200, n);
    repeat (2) step();
    END_OK = 1'b0;
    ACK_OK = 1'b0;
`ifdef I2C_POLL_TIMEOUT_EN
    repeat (TO - 1) step();
    compared++;
    if (TIMEOUT_ERR !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL timeout_early: got %b, expected 0", TIMEOUT_ERR);
    end
    step();
    m_nack[0] = 1'b1;
    m_to = 1'b1;
    check_results("timeout_flag");
    END_OK = 1'b1;
    run_txn(1, 1'b1, 8'($urandom_range(0, 255)), 1, 3, 1'b0);
    finish_round("timeout");
`else
    n = 0;
    for (int i = 0; i < 4 * TO; i++) begin
      step();
      if (GO === 1'b1) n++;
    end
    compared++;
    if (n != 0 || SLAVE_ADDRESS !== A0) begin
      mismatched++;
      $display("[TB] FAIL no_timeout: got go=%0d addr=%h, expected 0 %h", n, SLAVE_ADDRESS, A0);
    end
    check_results("no_timeout_hold");
    RESET_N = 1'b0;
    END_OK = 1'b1;
    step();
    RESET_N = 1'b1;
`endif
  endtask

  initial begin
    test_reset();
    test_basic_round();
    test_random_rounds();
    test_nack();
    test_enable_drop();
    test_reset_mid();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
